rv32_encoder: RTL and testbench
===============================

RV32_ENCODER -- requirements
Module: rv32_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning number of output FIFO entries (power of 2, at least 2).
REQ-002 SHALL have ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid and in_ready are both high.
- in_opcode  in  rv32_opcode_enum_t  operation to encode.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  signed immediate / offset.
- in_shamt  in  5  shift amount.
- in_csr  in  12  CSR address.
- in_zimm  in  5  CSR immediate.
- in_fence_pred, in_fence_succ  in  4 each  fence sets.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops head when out_valid and out_ready are both high.
- out_instr  out  32  encoded RV32I word.
- out_err  out  1  head entry is an encoding error.
- instr_count  out  16  encoded words accepted without error.
- err_count  out  16  requests accepted with an error.

Function
REQ-003 SHALL encode the accepted request in the accept cycle and push {instr, err} into the FIFO at that clock edge.
REQ-004 SHALL drive out_instr/out_err combinationally from the FIFO head; latency is 1 cycle from accept to out_valid when the FIFO is empty.
REQ-005 SHALL drive in_ready = (FIFO occupancy < FIFO_DEPTH); no push when full, even if a pop happens in the same cycle.
REQ-006 SHALL, on a simultaneous push and pop with 0 < occupancy < DEPTH, keep occupancy unchanged; read and write pointers wrap modulo DEPTH.
REQ-007 SHALL hold out_instr/out_err stable while out_valid=1 and out_ready=0.
REQ-008 Encoding rules (standard RV32I layout):
- U (LUI/AUIPC): [31:12]=in_imm[31:12].
- J (JAL): imm[20|10:1|11|19:12].
- B: imm[12|10:5], rs2, rs1, f3, imm[4:1|11].
- I (loads, JALR, ALU-imm): [31:20]=in_imm[11:0].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- R: funct7|rs2|rs1|f3|rd|0110011.
REQ-009 SHALL encode shifts as follows: SLLI/SRLI with funct7=0000000; SRAI and SUB with 0100000; SRL with 0000000; SRA with 0100000; [24:20]=in_shamt.
REQ-010 SHALL encode the fixed words: NOP=0x00000013, ECALL=0x00000073, EBREAK=0x00100073, FENCE.I=0x0000100F.
REQ-011 SHALL encode FENCE as {4'b0, pred, succ, 13'b0, 0001111} (rs1, rd, fm all 0).
REQ-012 SHALL encode CSR ops as csr|src|f3|rd|1110011, where src=in_rs1 for CSRRW/S/C and in_zimm for CSRRWI/SI/CI.
REQ-013 SHALL flag err=1 for each of these conditions:
- I/S immediate outside [-2048, 2047].
- B immediate outside [-4096, 4094] or bit0 set.
- J immediate outside [-1048576, 1048574] or bit0 set.
- U immediate with [11:0] nonzero.
- RV32_UNKNOWN or any unlisted opcode.
REQ-014 SHALL replace the instruction of any error entry with 0x00000013.
REQ-015 SHALL increment instr_count on an accept with err=0 and err_count on an accept with err=1; both counters saturate at 0xFFFF.

Reset
REQ-016 SHALL, on rst=1 at a clock edge, clear the FIFO pointers and occupancy and both counters; this holds even mid-transfer, and any in-flight entries are discarded.
REQ-017 SHALL output out_valid=0, out_instr=0, out_err=0, in_ready=1, instr_count=0, err_count=0 during and after reset.
REQ-018 SHALL ignore in_valid in any cycle in which rst=1.

Verification
REQ-019 Accept ADDI rd=1, rs1=0, imm=5, out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_err=0, instr_count=1.
REQ-020 Issue in sequence SUB rd=3,rs1=1,rs2=2; BEQ rs1=1,rs2=2,imm=8; JAL rd=0,imm=-4 -> outputs in order 0x402081B3, 0x00208463, 0xFFDFF06F.
REQ-021 Accept ADDI imm=2048, then BEQ imm=3 -> two entries, each with out_err=1 and out_instr=0x00000013; err_count=2, instr_count=0.
REQ-022 Hold out_ready=0 and offer 5 valid requests back-to-back -> in_ready=0 after 4 accepts; entries pop in FIFO order once out_ready=1; the 5th request is accepted on the first pop cycle +1.
REQ-023 Run continuous push with out_ready=1 for 2*DEPTH+3 requests -> no loss or reorder across pointer wrap.
REQ-024 Assert rst for 1 cycle with 3 entries queued -> next cycle out_valid=0, in_ready=1, both counters 0; a new request then encodes normally.

Source files
------------

// File: rtl/rv32_encoder_pkg.sv
// Opcode enumeration shared by the RV32I encoder and anything that drives it.
package rv32_encoder_pkg;

    typedef enum logic [5:0] {
        RV32_LUI, RV32_AUIPC, RV32_JAL, RV32_JALR,
        RV32_BEQ, RV32_BNE, RV32_BLT, RV32_BGE, RV32_BLTU, RV32_BGEU,
        RV32_LB, RV32_LH, RV32_LW, RV32_LBU, RV32_LHU,
        RV32_SB, RV32_SH, RV32_SW,
        RV32_ADDI, RV32_SLTI, RV32_SLTIU, RV32_XORI, RV32_ORI, RV32_ANDI,
        RV32_SLLI, RV32_SRLI, RV32_SRAI,
        RV32_ADD, RV32_SUB, RV32_SLL, RV32_SLT, RV32_SLTU, RV32_XOR,
        RV32_SRL, RV32_SRA, RV32_OR, RV32_AND,
        RV32_FENCE, RV32_FENCE_I, RV32_ECALL, RV32_EBREAK, RV32_NOP,
        RV32_CSRRW, RV32_CSRRS, RV32_CSRRC, RV32_CSRRWI, RV32_CSRRSI, RV32_CSRRCI,
        RV32_UNKNOWN
    } rv32_opcode_enum_t;

endpackage

// File: rtl/rv32_encoder.sv
// RV32I instruction encoder: encodes one request per accept and queues
// {err, instr} in a small output FIFO; error entries carry a NOP word.
module rv32_encoder
    import rv32_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  rv32_opcode_enum_t in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic [4:0]        in_shamt,
    input  logic [11:0]       in_csr,
    input  logic [4:0]        in_zimm,
    input  logic [3:0]        in_fence_pred,
    input  logic [3:0]        in_fence_succ,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic              out_err,
    output logic [15:0]       instr_count,
    output logic [15:0]       err_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_ST};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR};
    endfunction

    function automatic logic out_of_range(input logic signed [31:0] v, input int lo, input int hi);
        return (v < lo) || (v > hi);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic signed [31:0] imm_s;
    logic               bad_i, bad_b, bad_j, bad_u;
    logic [31:0]        raw_w, enc_instr;
    logic               enc_err;

    assign imm_s = signed'(in_imm);
    assign bad_i = out_of_range(imm_s, -2048, 2047);
    assign bad_b = out_of_range(imm_s, -4096, 4094) || in_imm[0];
    assign bad_j = out_of_range(imm_s, -1048576, 1048574) || in_imm[0];
    assign bad_u = |in_imm[11:0];

    always_comb begin
        raw_w   = NOP_W;
        enc_err = 1'b0;
        case (in_opcode)
            RV32_LUI:     begin raw_w = {in_imm[31:12], in_rd, OP_LUI};   enc_err = bad_u; end
            RV32_AUIPC:   begin raw_w = {in_imm[31:12], in_rd, OP_AUIPC}; enc_err = bad_u; end
            RV32_JAL: begin
                raw_w   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                enc_err = bad_j;
            end
            RV32_JALR:    begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR); enc_err = bad_i; end
            RV32_BEQ:     begin raw_w = enc_b(in_imm, in_rs2, in_rs1, 3'b000); enc_err = bad_b; end
            RV32_BNE:     begin raw_w = enc_b(in_imm, in_rs2, in_rs1, 3'b001); enc_err = bad_b; end
            RV32_BLT:     begin raw_w = enc_b(in_imm, in_rs2, in_rs1, 3'b100); enc_err = bad_b; end
            RV32_BGE:     begin raw_w = enc_b(in_imm, in_rs2, in_rs1, 3'b101); enc_err = bad_b; end
            RV32_BLTU:    begin raw_w = enc_b(in_imm, in_rs2, in_rs1, 3'b110); enc_err = bad_b; end
            RV32_BGEU:    begin raw_w = enc_b(in_imm, in_rs2, in_rs1, 3'b111); enc_err = bad_b; end
            RV32_LB:      begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OP_LOAD); enc_err = bad_i; end
            RV32_LH:      begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b001, in_rd, OP_LOAD); enc_err = bad_i; end
            RV32_LW:      begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD); enc_err = bad_i; end
            RV32_LBU:     begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b100, in_rd, OP_LOAD); enc_err = bad_i; end
            RV32_LHU:     begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b101, in_rd, OP_LOAD); enc_err = bad_i; end
            RV32_SB:      begin raw_w = enc_s(in_imm, in_rs2, in_rs1, 3'b000); enc_err = bad_i; end
            RV32_SH:      begin raw_w = enc_s(in_imm, in_rs2, in_rs1, 3'b001); enc_err = bad_i; end
            RV32_SW:      begin raw_w = enc_s(in_imm, in_rs2, in_rs1, 3'b010); enc_err = bad_i; end
            RV32_ADDI:    begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OP_IMM); enc_err = bad_i; end
            RV32_SLTI:    begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b010, in_rd, OP_IMM); enc_err = bad_i; end
            RV32_SLTIU:   begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b011, in_rd, OP_IMM); enc_err = bad_i; end
            RV32_XORI:    begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b100, in_rd, OP_IMM); enc_err = bad_i; end
            RV32_ORI:     begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b110, in_rd, OP_IMM); enc_err = bad_i; end
            RV32_ANDI:    begin raw_w = enc_i(in_imm[11:0], in_rs1, 3'b111, in_rd, OP_IMM); enc_err = bad_i; end
            // Shift immediates take the amount from in_shamt, so in_imm is not range-checked.
            RV32_SLLI:    raw_w = enc_i({7'b0000000, in_shamt}, in_rs1, 3'b001, in_rd, OP_IMM);
            RV32_SRLI:    raw_w = enc_i({7'b0000000, in_shamt}, in_rs1, 3'b101, in_rd, OP_IMM);
            RV32_SRAI:    raw_w = enc_i({7'b0100000, in_shamt}, in_rs1, 3'b101, in_rd, OP_IMM);
            RV32_ADD:     raw_w = enc_r(7'b0000000, in_rs2, in_rs1, 3'b000, in_rd);
            RV32_SUB:     raw_w = enc_r(7'b0100000, in_rs2, in_rs1, 3'b000, in_rd);
            RV32_SLL:     raw_w = enc_r(7'b0000000, in_rs2, in_rs1, 3'b001, in_rd);
            RV32_SLT:     raw_w = enc_r(7'b0000000, in_rs2, in_rs1, 3'b010, in_rd);
            RV32_SLTU:    raw_w = enc_r(7'b0000000, in_rs2, in_rs1, 3'b011, in_rd);
            RV32_XOR:     raw_w = enc_r(7'b0000000, in_rs2, in_rs1, 3'b100, in_rd);
            RV32_SRL:     raw_w = enc_r(7'b0000000, in_rs2, in_rs1, 3'b101, in_rd);
            RV32_SRA:     raw_w = enc_r(7'b0100000, in_rs2, in_rs1, 3'b101, in_rd);
            RV32_OR:      raw_w = enc_r(7'b0000000, in_rs2, in_rs1, 3'b110, in_rd);
            RV32_AND:     raw_w = enc_r(7'b0000000, in_rs2, in_rs1, 3'b111, in_rd);
            RV32_FENCE:   raw_w = {4'b0000, in_fence_pred, in_fence_succ, 13'b0, 7'b0001111};
            RV32_FENCE_I: raw_w = 32'h0000_100F;
            RV32_ECALL:   raw_w = 32'h0000_0073;
            RV32_EBREAK:  raw_w = 32'h0010_0073;
            RV32_NOP:     raw_w = NOP_W;
            RV32_CSRRW:   raw_w = {in_csr, in_rs1,  3'b001, in_rd, OP_SYS};
            RV32_CSRRS:   raw_w = {in_csr, in_rs1,  3'b010, in_rd, OP_SYS};
            RV32_CSRRC:   raw_w = {in_csr, in_rs1,  3'b011, in_rd, OP_SYS};
            RV32_CSRRWI:  raw_w = {in_csr, in_zimm, 3'b101, in_rd, OP_SYS};
            RV32_CSRRSI:  raw_w = {in_csr, in_zimm, 3'b110, in_rd, OP_SYS};
            RV32_CSRRCI:  raw_w = {in_csr, in_zimm, 3'b111, in_rd, OP_SYS};
            default:      enc_err = 1'b1;
        endcase
        enc_instr = enc_err ? NOP_W : raw_w;
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [15:0]   icnt_q, icnt_d, ecnt_q, ecnt_d;
    logic [32:0]   mem_q [FIFO_DEPTH];
    logic [32:0]   head;
    logic          push, pop;

    // rst masks the handshake outputs combinationally so the reset cycle itself is clean.
    assign in_ready    = rst || (occ_q < DEPTH_L);
    assign out_valid   = !rst && (occ_q != '0);
    assign push        = in_valid && in_ready && !rst;
    assign pop         = out_valid && out_ready;
    assign head        = mem_q[rd_ptr_q];
    assign out_instr   = out_valid ? head[31:0] : '0;
    assign out_err     = out_valid && head[32];
    assign instr_count = rst ? '0 : icnt_q;
    assign err_count   = rst ? '0 : ecnt_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d    = occ_q;
        if (push && !pop) occ_d = occ_q + 1'b1;
        else if (!push && pop) occ_d = occ_q - 1'b1;
        icnt_d   = (push && !enc_err) ? sat_inc(icnt_q) : icnt_q;
        ecnt_d   = (push && enc_err) ? sat_inc(ecnt_q) : ecnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            icnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            icnt_q   <= icnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {enc_err, enc_instr};
    end

endmodule

// File: tb/tb_rv32_encoder.sv
// Directed bench for rv32_encoder: hand-encoded RV32I words, FIFO backpressure,
// pointer wrap and mid-transfer reset.
module tb_rv32_encoder;
    import rv32_encoder_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    rv32_opcode_enum_t in_opcode;
    logic [4:0]        in_rd, in_rs1, in_rs2, in_shamt, in_zimm;
    logic [31:0]       in_imm;
    logic [11:0]       in_csr;
    logic [3:0]        in_fence_pred, in_fence_succ;
    logic              out_valid, out_ready, out_err;
    logic [31:0]       out_instr;
    logic [15:0]       instr_count, err_count;

    int errors = 0;
    int checks = 0;
    int exp_ic = 0;
    int exp_ec = 0;

    rv32_encoder #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_shamt(in_shamt), .in_csr(in_csr), .in_zimm(in_zimm),
        .in_fence_pred(in_fence_pred), .in_fence_succ(in_fence_succ),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .instr_count(instr_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addi_w(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    task automatic set_req(input rv32_opcode_enum_t op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    // One accept with out_ready=1; the entry must be at the head one cycle later.
    task automatic enc(input rv32_opcode_enum_t op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [31:0] exp_i, input logic exp_e, input string tag);
        set_req(op, rd, rs1, rs2, imm);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (exp_e) exp_ec++; else exp_ic++;
        chk(tag, {31'd0, out_valid, out_err, out_instr}, {31'd0, 1'b1, exp_e, exp_i});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = RV32_NOP; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        in_shamt = '0; in_csr = '0; in_zimm = '0; in_fence_pred = '0; in_fence_succ = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs", {out_valid, out_err, out_instr, in_ready}, {1'b0, 1'b0, 32'd0, 1'b1});
        chk("reset_counts", {instr_count, err_count}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        enc(RV32_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0, "addi_basic");
        chk("addi_count", instr_count, 16'd1);

        enc(RV32_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0, "seq_sub");
        enc(RV32_BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463, 1'b0, "seq_beq");
        enc(RV32_JAL, 5'd0, 5'd0, 5'd0, -32'sd4, 32'hFFDF_F06F, 1'b0, "seq_jal");

        enc(RV32_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0000_0013, 1'b1, "err_addi_2048");
        enc(RV32_BEQ, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0000_0013, 1'b1, "err_beq_odd");
        chk("err_counts", {instr_count, err_count}, {16'(exp_ic), 16'(exp_ec)});

        enc(RV32_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, "lui");
        enc(RV32_SW, 5'd0, 5'd2, 5'd3, -32'sd4, 32'hFE31_2E23, 1'b0, "sw_neg");
        in_shamt = 5'd3;
        enc(RV32_SRAI, 5'd1, 5'd1, 5'd0, 32'd0, 32'h4030_D093, 1'b0, "srai");
        enc(RV32_JALR, 5'd1, 5'd5, 5'd0, 32'd0, 32'h0002_80E7, 1'b0, "jalr");
        in_csr = 12'h300; in_zimm = 5'd5;
        enc(RV32_CSRRWI, 5'd2, 5'd0, 5'd0, 32'd0, 32'h3002_D173, 1'b0, "csrrwi");
        in_csr = 12'hC00;
        enc(RV32_CSRRS, 5'd1, 5'd2, 5'd0, 32'd0, 32'hC001_20F3, 1'b0, "csrrs");
        in_fence_pred = 4'hF; in_fence_succ = 4'hF;
        enc(RV32_FENCE, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0FF0_000F, 1'b0, "fence");
        enc(RV32_FENCE_I, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_100F, 1'b0, "fence_i");
        enc(RV32_ECALL, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0073, 1'b0, "ecall");
        enc(RV32_EBREAK, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0010_0073, 1'b0, "ebreak");
        enc(RV32_ADDI, 5'd0, 5'd0, 5'd0, -32'sd2048, 32'h8000_0013, 1'b0, "addi_min_imm");
        enc(RV32_BEQ, 5'd0, 5'd0, 5'd0, 32'd4094, 32'h7E00_0FE3, 1'b0, "beq_max_imm");
        enc(RV32_BEQ, 5'd0, 5'd0, 5'd0, 32'd4096, 32'h0000_0013, 1'b1, "err_beq_4096");
        enc(RV32_SW, 5'd0, 5'd2, 5'd3, 32'd2048, 32'h0000_0013, 1'b1, "err_sw_2048");
        enc(RV32_JAL, 5'd0, 5'd0, 5'd0, 32'd1048576, 32'h0000_0013, 1'b1, "err_jal_range");
        enc(RV32_LUI, 5'd1, 5'd0, 5'd0, 32'h0000_1001, 32'h0000_0013, 1'b1, "err_lui_low");
        enc(RV32_UNKNOWN, 5'd1, 5'd0, 5'd0, 32'd0, 32'h0000_0013, 1'b1, "err_unknown");
        enc(rv32_opcode_enum_t'(6'd63), 5'd1, 5'd0, 5'd0, 32'd0, 32'h0000_0013, 1'b1, "err_unlisted");
        @(posedge clk); #1;
        chk("counts_mid", {instr_count, err_count}, {16'(exp_ic), 16'(exp_ec)});

        // Backpressure: fill the FIFO, offer a fifth request, then drain in order.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(RV32_ADDI, 5'(k + 1), 5'd0, 5'd0, 32'(k * 16));
            @(posedge clk); #1;
        end
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_head", {out_valid, out_err, out_instr}, {1'b1, 1'b0, addi_w(5'd1, 12'd0)});
        set_req(RV32_ADDI, 5'd5, 5'd0, 5'd0, 32'd64);
        @(posedge clk); #1;
        chk("full_still_blocked", in_ready, 1'b0);
        chk("hold_head", {out_valid, out_err, out_instr}, {1'b1, 1'b0, addi_w(5'd1, 12'd0)});
        chk("full_count", instr_count, 16'(exp_ic + 4));
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("pop_frees_slot", in_ready, 1'b1);
        chk("pop_head2", {out_valid, out_instr}, {1'b1, addi_w(5'd2, 12'd16)});
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_ic += 5;
        chk("fifth_accepted", instr_count, 16'(exp_ic));
        chk("pop_head3", {out_valid, out_instr}, {1'b1, addi_w(5'd3, 12'd32)});
        @(posedge clk); #1;
        chk("pop_head4", {out_valid, out_instr}, {1'b1, addi_w(5'd4, 12'd48)});
        @(posedge clk); #1;
        chk("pop_head5", {out_valid, out_instr}, {1'b1, addi_w(5'd5, 12'd64)});
        @(posedge clk); #1;
        chk("drained", {out_valid, out_instr}, {1'b0, 32'd0});

        // Continuous streaming across several pointer wraps.
        for (int i = 0; i < 11; i++) begin
            enc(RV32_ADDI, 5'(i + 7), 5'd0, 5'd0, 32'(i * 7 + 1),
                addi_w(5'(i + 7), 12'(i * 7 + 1)), 1'b0, $sformatf("wrap_%0d", i));
        end
        @(posedge clk); #1;
        chk("wrap_counts", {instr_count, err_count}, {16'(exp_ic), 16'(exp_ec)});

        // Reset with three entries queued and a request offered during reset.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(RV32_ADDI, 5'(k + 1), 5'd0, 5'd0, 32'd1);
            @(posedge clk); #1;
        end
        chk("pre_reset_valid", out_valid, 1'b1);
        rst = 1'b1;
        set_req(RV32_ADDI, 5'd9, 5'd0, 5'd0, 32'd9);
        #1;
        chk("during_reset", {out_valid, out_err, out_instr, in_ready, instr_count, err_count},
            {1'b0, 1'b0, 32'd0, 1'b1, 16'd0, 16'd0});
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        exp_ic = 0;
        exp_ec = 0;
        chk("after_reset", {out_valid, out_err, out_instr, in_ready, instr_count, err_count},
            {1'b0, 1'b0, 32'd0, 1'b1, 16'd0, 16'd0});
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("reset_ignored_in_valid", {out_valid, instr_count}, {1'b0, 16'd0});
        enc(RV32_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0, "post_reset_addi");
        chk("post_reset_count", {instr_count, err_count}, {16'd1, 16'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
